alu_result_buffer: RTL and testbench

Registered result buffer sitting directly downstream of `ALU_32bit`. It captures each valid ALU result, together with its opcode and its Zero/Negative/Carry/Overflow flags, into a DEPTH-entry FIFO. It presents entries to the next stage (writeback) over a valid/ready handshake. It also keeps sticky flag status and a saturating overflow counter for the stream of accepted results.

---
 rtl/alu_result_buffer_if.sv | 46 ++++
 rtl/alu_result_buffer.sv | 88 ++++++++
 tb/tb_alu_result_buffer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the ALU, the result buffer and writeback.
// The master side is the environment, and the slave side is the buffer.
interface alu_result_buffer_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                    In_Valid;
    logic                    In_Ready;
    logic [2:0]              ALU_Sel;
    logic signed [WIDTH-1:0] ALU_Out;
    logic                    Zero;
    logic                    Negative;
    logic                    Carry;
    logic                    Overflow;

    logic                    Out_Valid;
    logic                    Out_Ready;
    logic [WIDTH-1:0]        Out_Data;
    logic [2:0]              Out_Sel;
    logic [3:0]              Out_Flags;

    logic                    Sticky_Clr;
    logic [3:0]              Sticky_Flags;
    logic [7:0]              Ovf_Count;
    logic [CW-1:0]           Count;

    modport master (
        output In_Valid, ALU_Sel, ALU_Out,
        output Zero, Negative, Carry, Overflow,
        output Out_Ready, Sticky_Clr,
        input  In_Ready, Out_Valid, Out_Data,
        input  Out_Sel, Out_Flags,
        input  Sticky_Flags, Ovf_Count, Count
    );

    modport slave (
        input  In_Valid, ALU_Sel, ALU_Out,
        input  Zero, Negative, Carry, Overflow,
        input  Out_Ready, Sticky_Clr,
        output In_Ready, Out_Valid, Out_Data,
        output Out_Sel, Out_Flags,
        output Sticky_Flags, Ovf_Count, Count
    );
endinterface

// File: rtl/alu_result_buffer.sv
// Result FIFO downstream of the ALU with sticky flag status
// and a saturating overflow counter.
module alu_result_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    alu_result_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = WIDTH + 7;

    // Entry layout: {data, sel, Z, N, C, V}
    typedef logic [EW-1:0] entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    sticky_q, sticky_d;
    logic [7:0]    ovf_q, ovf_d;
    logic [7:0]    ovf_base;
    logic          full, empty, push, pop;
    logic [3:0]    in_flags;
    entry_t        head;

    assign full     = (cnt_q == CW'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign in_flags = {bus.Zero, bus.Negative,
                       bus.Carry, bus.Overflow};

    assign bus.In_Ready = !full && !rst;
    assign push = bus.In_Valid && bus.In_Ready;
    assign pop  = !empty && bus.Out_Ready && !rst;

    assign head          = mem_q[rptr_q];
    assign bus.Out_Valid = !empty;
    assign bus.Out_Data  = empty ? '0 : head[EW-1 -: WIDTH];
    assign bus.Out_Sel   = empty ? '0 : head[6:4];
    assign bus.Out_Flags = empty ? '0 : head[3:0];

    assign bus.Count        = cnt_q;
    assign bus.Sticky_Flags = sticky_q;
    assign bus.Ovf_Count    = ovf_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end

    // Clear is applied before the same-cycle push is folded in
    always_comb begin
        sticky_d = bus.Sticky_Clr ? 4'b0 : sticky_q;
        ovf_base = bus.Sticky_Clr ? 8'd0 : ovf_q;
        ovf_d    = ovf_base;
        if (push) sticky_d = sticky_d | in_flags;
        if (push && bus.Overflow && ovf_base != 8'hFF)
            ovf_d = ovf_base + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            sticky_q <= '0;
            ovf_q    <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q] <= {bus.ALU_Out, bus.ALU_Sel, in_flags};
    end
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed and random checks of alu_result_buffer against a
// queue-based reference model.
module tb_alu_result_buffer;
    localparam int W = 32;
    localparam int D = 4;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  s;
        logic [3:0]  f;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    ent_t mq[$];
    logic [3:0] ms;
    int         mo;

    alu_result_buffer_if #(.WIDTH(W), .DEPTH(D)) bus ();

    alu_result_buffer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(bit v, logic [31:0] d, logic [2:0] s,
                       logic [3:0] f, bit ordy, bit clr);
        bus.In_Valid   = v;
        bus.ALU_Out    = d;
        bus.ALU_Sel    = s;
        {bus.Zero, bus.Negative, bus.Carry, bus.Overflow} = f;
        bus.Out_Ready  = ordy;
        bus.Sticky_Clr = clr;
    endtask

    // One clock: advance the model from the driven inputs, then compare
    task automatic tick();
        bit   push, pop;
        ent_t e;
        logic [3:0] f;
        f = {bus.Zero, bus.Negative, bus.Carry, bus.Overflow};
        push = !rst && bus.In_Valid && (mq.size() < D);
        pop  = !rst && bus.Out_Ready && (mq.size() != 0);
        e.d = bus.ALU_Out;
        e.s = bus.ALU_Sel;
        e.f = f;
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            ms = 4'b0;
            mo = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(e);
            if (bus.Sticky_Clr) begin
                ms = 4'b0;
                mo = 0;
            end
            if (push) begin
                ms = ms | f;
                if (f[0] && mo < 255) mo++;
            end
        end
        chk("count", 64'(bus.Count), 64'(mq.size()));
        chk("out_valid", 64'(bus.Out_Valid), 64'(mq.size() != 0));
        chk("out_data", 64'(bus.Out_Data),
            mq.size() != 0 ? 64'(mq[0].d) : 64'd0);
        chk("out_sel", 64'(bus.Out_Sel),
            mq.size() != 0 ? 64'(mq[0].s) : 64'd0);
        chk("out_flags", 64'(bus.Out_Flags),
            mq.size() != 0 ? 64'(mq[0].f) : 64'd0);
        chk("sticky", 64'(bus.Sticky_Flags), 64'(ms));
        chk("ovf_count", 64'(bus.Ovf_Count), 64'(mo));
        chk("in_ready", 64'(bus.In_Ready),
            64'(!rst && mq.size() < D));
    endtask

    initial begin
        ms = 4'b0;
        mo = 0;
        drv(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        chk("rst_count", 64'(bus.Count), 64'd0);
        chk("rst_in_ready", 64'(bus.In_Ready), 64'd0);
        chk("rst_out_valid", 64'(bus.Out_Valid), 64'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 64'(bus.In_Ready), 64'd1);

        // Basic flow
        drv(1, 32'd8, 3'b100, 4'b0000, 1, 0);
        tick();
        chk("t1_valid", 64'(bus.Out_Valid), 64'd1);
        chk("t1_data", 64'(bus.Out_Data), 64'd8);
        chk("t1_sel", 64'(bus.Out_Sel), 64'b100);
        drv(0, 0, 0, 0, 1, 0);
        tick();
        chk("t1_count", 64'(bus.Count), 64'd0);
        chk("t1_sticky", 64'(bus.Sticky_Flags), 64'b0000);

        // Zero, negative and overflow results
        drv(1, 32'd0, 3'b100, 4'b1000, 0, 0);
        tick();
        drv(1, -32'sd7, 3'b101, 4'b0100, 0, 0);
        tick();
        drv(1, 32'h8000_0000, 3'b100, 4'b0101, 0, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        tick();
        chk("t2_count", 64'(bus.Count), 64'd3);
        chk("t2_sticky", 64'(bus.Sticky_Flags), 64'b1101);
        chk("t2_ovf", 64'(bus.Ovf_Count), 64'd1);
        chk("t2_head0", 64'(bus.Out_Data), 64'd0);
        chk("t2_flags0", 64'(bus.Out_Flags), 64'b1000);
        drv(0, 0, 0, 0, 1, 0);
        tick();
        chk("t2_head1", 64'(bus.Out_Data), 64'hFFFF_FFF9);
        chk("t2_sel1", 64'(bus.Out_Sel), 64'b101);
        tick();
        chk("t2_head2", 64'(bus.Out_Data), 64'h8000_0000);
        chk("t2_flags2", 64'(bus.Out_Flags), 64'b0101);
        tick();
        chk("t2_empty", 64'(bus.Out_Valid), 64'd0);

        // Full and backpressure
        for (int i = 0; i < 5; i++) begin
            drv(1, 32'(1000 + i), 3'b000, 4'b0000, 0, 0);
            tick();
            if (i == 3)
                chk("t3_full_ready", 64'(bus.In_Ready), 64'd0);
        end
        chk("t3_count_full", 64'(bus.Count), 64'd4);
        chk("t3_head", 64'(bus.Out_Data), 64'd1000);
        drv(1, 32'd1004, 3'b000, 4'b0000, 1, 0);
        tick();
        chk("t3_count_pop", 64'(bus.Count), 64'd3);
        chk("t3_ready_back", 64'(bus.In_Ready), 64'd1);
        drv(1, 32'd1004, 3'b000, 4'b0000, 0, 0);
        tick();
        chk("t3_count_refill", 64'(bus.Count), 64'd4);
        drv(0, 0, 0, 0, 1, 0);
        for (int i = 1; i < 5; i++) begin
            chk("t3_drain", 64'(bus.Out_Data), 64'(1000 + i));
            tick();
        end
        chk("t3_empty", 64'(bus.Count), 64'd0);

        // Simultaneous push/pop across pointer wrap
        drv(1, 32'd2000, 3'b010, 4'b0000, 0, 0);
        tick();
        drv(1, 32'd2001, 3'b010, 4'b0000, 0, 0);
        tick();
        for (int k = 0; k < 10; k++) begin
            drv(1, 32'(2002 + k), 3'b010, 4'b0000, 1, 0);
            tick();
            chk("t4_count", 64'(bus.Count), 64'd2);
            chk("t4_head", 64'(bus.Out_Data), 64'(2001 + k));
        end
        drv(0, 0, 0, 0, 1, 0);
        tick();
        tick();

        // Overflow saturation, then clear with a pushed overflow
        for (int i = 0; i < 260; i++) begin
            drv(1, $urandom, 3'(i), 4'b0001, 1, 0);
            tick();
        end
        chk("t5_sat", 64'(bus.Ovf_Count), 64'd255);
        drv(1, 32'd77, 3'b011, 4'b0011, 1, 1);
        tick();
        chk("t5_clr_ovf", 64'(bus.Ovf_Count), 64'd1);
        chk("t5_clr_sticky", 64'(bus.Sticky_Flags), 64'b0011);
        drv(0, 0, 0, 0, 1, 1);
        tick();
        chk("t5_clr_only", 64'(bus.Sticky_Flags), 64'b0000);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) begin
            drv(1, 32'(3000 + i), 3'b001, 4'b1111, 0, 0);
            tick();
        end
        chk("t6_count3", 64'(bus.Count), 64'd3);
        drv(1, 32'd3999, 3'b001, 4'b1111, 1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        #1;
        chk("t6_count", 64'(bus.Count), 64'd0);
        chk("t6_valid", 64'(bus.Out_Valid), 64'd0);
        chk("t6_data", 64'(bus.Out_Data), 64'd0);
        chk("t6_sticky", 64'(bus.Sticky_Flags), 64'd0);
        chk("t6_ovf", 64'(bus.Ovf_Count), 64'd0);
        chk("t6_ready", 64'(bus.In_Ready), 64'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drv(1'($urandom_range(0, 1)), $urandom,
                3'($urandom), 4'($urandom),
                1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 15) == 0));
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
